// File: rtl/frame_gen_if.sv
// Frame output bus: byte stream plus per-frame control and priority sideband.
interface frame_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] f_data_in;
  logic              f_rec_data_valid;
  logic              f_rec_frame_valid;
  logic [23:0]       f_ctrl_in;
  logic              f_hi_priority;

  modport master (
    output f_data_in, f_rec_data_valid, f_rec_frame_valid, f_ctrl_in, f_hi_priority
  );
  modport slave (
    input f_data_in, f_rec_data_valid, f_rec_frame_valid, f_ctrl_in, f_hi_priority
  );
endinterface

// File: rtl/frame_gen.sv
// Run-based frame generator: each frame is HEAD pad, BODY payload, TAIL pad,
// separated by optional idle gaps; a run is cfg_num frames or stops early on abort.
module frame_gen #(
  parameter int                DATA_W    = 8,
  parameter int                LEN_W     = 12,
  parameter int                CNT_W     = 8,
  parameter int                PAD_BYTES = 4,
  parameter logic [DATA_W-1:0] HEAD_PAT  = 8'h00,
  parameter logic [DATA_W-1:0] BODY_PAT  = 8'hFF
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_num,
  input  logic [7:0]       cfg_gap,
  input  logic             cfg_hi_priority,
  input  logic             cfg_alt_pri,
  input  logic             cfg_incr,
  frame_gen_if.master      fo,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] frames_sent
);
  // Phase counter must hold both body lengths and gap lengths.
  localparam int CW = (LEN_W > 8) ? LEN_W : 8;

  typedef enum logic [2:0] {IDLE, HEAD, BODY, TAIL, GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] rem_q;
  logic [7:0]       gap_q;
  logic             incr_q, alt_q, pri_q, abort_pend;

  logic [CW-1:0] pad_last, body_last, gap_last;
  logic          len_ok, abort_eff, more, frame_end;
  logic          launch, reject, empty, done_d;
  logic          valid, first;
  logic [11:0]   len12;

  assign pad_last  = CW'(PAD_BYTES - 1);
  assign body_last = CW'(len_q - LEN_W'(2 * PAD_BYTES + 1));
  assign gap_last  = CW'(gap_q) - CW'(1);
  assign len_ok    = ({1'b0, cfg_len} >= (LEN_W + 1)'(2 * PAD_BYTES + 1));
  assign abort_eff = abort | abort_pend;
  assign more      = (rem_q > CNT_W'(1));
  assign frame_end = (state_q == TAIL) && (cnt_q == pad_last);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    reject  = 1'b0;
    empty   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (!len_ok)              reject = 1'b1;
        else if (cfg_num == '0) begin
          empty  = 1'b1;
          done_d = 1'b1;
        end else begin
          launch  = 1'b1;
          state_d = HEAD;
        end
      end
      HEAD: if (cnt_q == pad_last)  state_d = BODY;
      BODY: if (cnt_q == body_last) state_d = TAIL;
      TAIL: if (cnt_q == pad_last) begin
        if (more && !abort_eff) state_d = (gap_q == '0) ? HEAD : GAP;
        else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        // Abort inside a gap does not wait for another frame.
        if (abort_eff) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == gap_last) state_d = HEAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      gap_q       <= '0;
      incr_q      <= 1'b0;
      alt_q       <= 1'b0;
      pri_q       <= 1'b0;
      abort_pend  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      frames_sent <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
      done       <= done_d;
      err        <= reject;
      abort_pend <= (state_d == IDLE) ? 1'b0 : (abort_pend | (abort & (state_q != IDLE)));
      if (launch || empty) begin
        len_q       <= cfg_len;
        rem_q       <= cfg_num;
        gap_q       <= cfg_gap;
        incr_q      <= cfg_incr;
        alt_q       <= cfg_alt_pri;
        pri_q       <= cfg_hi_priority;
        frames_sent <= '0;
      end else if (frame_end) begin
        rem_q <= rem_q - CNT_W'(1);
        if (alt_q) pri_q <= ~pri_q;
        if (frames_sent != '1) frames_sent <= frames_sent + CNT_W'(1);
      end
    end
  end

  assign valid = (state_q == HEAD) || (state_q == BODY) || (state_q == TAIL);
  assign first = (state_q == HEAD) && (cnt_q == '0);
  assign len12 = 12'(len_q);
  assign busy  = (state_q != IDLE);

  assign fo.f_rec_data_valid  = valid;
  assign fo.f_rec_frame_valid = first;
  assign fo.f_ctrl_in         = first ? {len12, len12} : 24'h000000;
  assign fo.f_hi_priority     = valid & pri_q;
  assign fo.f_data_in         = (state_q != BODY) ? HEAD_PAT :
                                incr_q ? DATA_W'(cnt_q) : BODY_PAT;
endmodule

// File: tb/tb_frame_gen.sv
// Directed and randomized runs of frame_gen checked cycle by cycle against a
// frame-list model built from the length / count / gap / priority rules.
module tb_frame_gen;
  localparam int PAD = 4;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [11:0] cfg_len = '0;
  logic [7:0]  cfg_num = '0, cfg_gap = '0;
  logic        cfg_hi_priority = 1'b0, cfg_alt_pri = 1'b0, cfg_incr = 1'b0;
  logic        busy, done, err;
  logic [7:0]  frames_sent;

  int n_cmp = 0;
  int n_bad = 0;

  frame_gen_if #(.DATA_W(8)) fo ();

  frame_gen dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_num(cfg_num), .cfg_gap(cfg_gap),
    .cfg_hi_priority(cfg_hi_priority), .cfg_alt_pri(cfg_alt_pri), .cfg_incr(cfg_incr),
    .fo(fo), .busy(busy), .done(done), .err(err), .frames_sent(frames_sent)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        valid;
    logic        fv;
    logic        pri;
    logic        busy;
    logic        done;
    logic [7:0]  data;
    logic [23:0] ctrl;
  } obs_t;

  function automatic obs_t sample();
    obs_t o;
    o.valid = fo.f_rec_data_valid;
    o.fv    = fo.f_rec_frame_valid;
    o.pri   = fo.f_hi_priority;
    o.busy  = busy;
    o.done  = done;
    o.data  = fo.f_data_in;
    o.ctrl  = fo.f_ctrl_in;
    return o;
  endfunction

  function automatic obs_t idle_obs(input logic d);
    obs_t o;
    o = '0;
    o.done = d;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One run: model the expected per-cycle stream, then drive and compare.
  task automatic run_check(input int len, input int num, input int gap,
                           input bit hi, input bit alt, input bit incr,
                           input int abort_at, input int restart_at, input string tag);
    obs_t exp_q[$];
    obs_t e;
    int   k = 0;
    int   fs = 0;
    bit   stop = 0;
    for (int f = 0; f < num && !stop; f++) begin
      for (int b = 0; b < len; b++) begin
        e       = '0;
        e.valid = 1'b1;
        e.busy  = 1'b1;
        e.fv    = (b == 0);
        e.pri   = hi ^ (alt & f[0]);
        e.ctrl  = (b == 0) ? {12'(len), 12'(len)} : 24'h0;
        if (b < PAD || b >= len - PAD) e.data = 8'h00;
        else                           e.data = incr ? 8'(b - PAD) : 8'hFF;
        exp_q.push_back(e);
        k++;
      end
      fs++;
      if (f == num - 1 || (abort_at >= 0 && abort_at < k)) stop = 1;
      else begin
        for (int g = 0; g < gap; g++) begin
          e      = '0;
          e.busy = 1'b1;
          exp_q.push_back(e);
          k++;
          if (abort_at == k - 1) begin
            stop = 1;
            break;
          end
        end
      end
    end
    exp_q.push_back(idle_obs(1'b1));

    @(negedge clk_sys);
    cfg_len = 12'(len); cfg_num = 8'(num); cfg_gap = 8'(gap);
    cfg_hi_priority = hi; cfg_alt_pri = alt; cfg_incr = incr;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s.cyc%0d", tag, i), 64'(sample()), 64'(exp_q[i]));
      abort = (i == abort_at);
      start = (i == restart_at);
      if (i == restart_at) begin
        cfg_len = 12'($urandom_range(9, 200)); cfg_num = 8'($urandom_range(1, 9));
        cfg_gap = 8'($urandom_range(0, 9)); cfg_hi_priority = ~hi;
        cfg_alt_pri = ~alt; cfg_incr = ~incr;
      end
      @(negedge clk_sys);
    end
    abort = 1'b0;
    start = 1'b0;
    chk({tag, ".frames_sent"}, 64'(frames_sent), 64'(fs));
    chk({tag, ".after_done"}, 64'(sample()), 64'(idle_obs(1'b0)));
  endtask

  initial begin
    int len, num, gap, ab, rs;
    repeat (2) @(negedge clk_sys);
    chk("reset.outputs", 64'(sample()), 64'(idle_obs(1'b0)));
    chk("reset.err_cnt", 64'({err, frames_sent}), 64'(0));
    reset = 1'b0;

    run_check(512, 64, 0, 1, 0, 0, -1, -1, "baseline");
    run_check(300, 3, 5, 0, 1, 1, -1, -1, "incr_alt_gap");

    // Illegal length: err pulse only.
    @(negedge clk_sys);
    cfg_len = 12'd8; cfg_num = 8'd4; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    chk("illegal.pulse", 64'({err, busy, fo.f_rec_data_valid, done}), 64'(4'b1000));
    @(negedge clk_sys);
    chk("illegal.after", 64'({err, busy, fo.f_rec_data_valid, done}), 64'(4'b0000));

    // Zero count: done pulse only, frames_sent cleared.
    cfg_len = 12'd64; cfg_num = 8'd0; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    chk("zero_num.pulse", 64'(sample()), 64'(idle_obs(1'b1)));
    chk("zero_num.cnt", 64'({err, frames_sent}), 64'(0));
    @(negedge clk_sys);
    chk("zero_num.after", 64'(sample()), 64'(idle_obs(1'b0)));

    // Abort mid-frame 2 of 10 (frames 0,1 plus gaps occupy cycles 0..43).
    run_check(20, 10, 2, 1, 0, 0, 50, -1, "abort_mid");
    run_check(12, 4, 3, 0, 1, 0, 12 + 1, -1, "abort_gap");
    run_check(12, 4, 0, 1, 1, 1, 11, -1, "abort_last_tail");

    // Abort while idle must not carry into the next run.
    @(negedge clk_sys);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    run_check(15, 2, 1, 0, 0, 1, -1, -1, "idle_abort");

    run_check(30, 3, 3, 0, 1, 0, -1, 15, "start_busy");

    // Reset in the middle of a body.
    @(negedge clk_sys);
    cfg_len = 12'd40; cfg_num = 8'd2; cfg_gap = 8'd0; cfg_incr = 1'b1; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (10) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("rst_mid.outputs", 64'(sample()), 64'(idle_obs(1'b0)));
    chk("rst_mid.err_cnt", 64'({err, frames_sent}), 64'(0));
    repeat (3) @(negedge clk_sys);
    chk("rst_mid.no_done", 64'(sample()), 64'(idle_obs(1'b0)));

    // Reset wins over a simultaneous start.
    start = 1'b1; reset = 1'b1;
    @(negedge clk_sys);
    start = 1'b0; reset = 1'b0;
    chk("rst_vs_start", 64'(sample()), 64'(idle_obs(1'b0)));
    run_check(40, 1, 0, 1, 0, 1, -1, -1, "post_reset");

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(9, 90);
      num = $urandom_range(1, 5);
      gap = $urandom_range(0, 6);
      ab  = -1;
      rs  = -1;
      if ($urandom_range(0, 1) == 1) ab = $urandom_range(0, num * (len + gap));
      else if ($urandom_range(0, 1) == 1) rs = $urandom_range(0, len - 2);
      run_check(len, num, gap, 1'($urandom), 1'($urandom), 1'($urandom), ab, rs,
                $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
